// File: rtl/bcd_result_conv_if.sv
// bcd_result_conv_if
//   Result bus between the 64-bit integer calculator and the binary-to-BCD
//   converter.
//   master : calculator side   drives start/sum/sign, receives busy/done/bcd/neg/ndig
//   slave  : converter side    receives start/sum/sign, drives busy/done/bcd/neg/ndig
//   Signals:
//     start  conversion request (sampled by the converter when it can accept)
//     sum    WIDTH-bit binary result
//     sign   calculator sign bit (meaningful only in signed-magnitude builds)
//     busy   conversion in progress
//     done   one-cycle completion pulse
//     bcd    4*DIGITS packed BCD, units digit at [3:0]
//     neg    negative flag
//     ndig   significant-digit count, 1..DIGITS
interface bcd_result_conv_if #(
  parameter int WIDTH  = 64,
  parameter int DIGITS = 20
);
  logic                  start;
  logic [WIDTH-1:0]      sum;
  logic                  sign;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  neg;
  logic [4:0]            ndig;

  modport master (output start, sum, sign, input busy, done, bcd, neg, ndig);
  modport slave  (input start, sum, sign, output busy, done, bcd, neg, ndig);
endinterface

// File: rtl/bcd_result_conv.sv
// bcd_result_conv
//   Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
//   sitting downstream of the integer calculator. A start pulse captures the
//   calculator result; WIDTH clocks later the packed digits, a negative flag
//   and a significant-digit count are presented with a one-cycle done pulse.
//   Outputs hold until the next completion.
//
//   Ports:
//     clk  sole clock, rising edge
//     rst  synchronous, active-high reset
//     bus  bcd_result_conv_if.slave (start/sum/sign in, busy/done/bcd/neg/ndig out)
//
//   Build option:
//     BCD_SIGNED_MAG_EN  when defined, sum/sign are treated as a two's
//                        complement value and its magnitude is converted,
//                        with neg reporting the sign. When undefined, sum is
//                        unsigned, sign is ignored and neg is constant 0.
module bcd_result_conv #(
  parameter int WIDTH  = 64,
  parameter int DIGITS = 20   // requires 10**DIGITS > 2**WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  bcd_result_conv_if.slave        bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                state;
  logic [WIDTH-1:0]      sreg;
  logic [4*DIGITS-1:0]   acc;
  logic [CW-1:0]         cnt;
  logic                  neg_cap;

  logic [4*DIGITS-1:0]   acc_adj;
  logic [4*DIGITS-1:0]   acc_nxt;
  logic [4:0]            ndig_nxt;
  logic [WIDTH-1:0]      mag;
  logic                  neg_in;

`ifdef BCD_SIGNED_MAG_EN
  // Two's complement negate; the most negative value maps onto itself,
  // which read as unsigned is exactly its magnitude.
  assign mag    = bus.sign ? (~bus.sum + WIDTH'(1)) : bus.sum;
  assign neg_in = bus.sign;
`else
  logic unused_sign;
  assign unused_sign = bus.sign;
  assign mag         = bus.sum;
  assign neg_in      = 1'b0;
`endif

  // One double-dabble step: correct digits >= 5, then shift in the next
  // binary bit. The top bit of acc_adj is dropped because DIGITS is sized
  // so that no carry can leave the most significant digit.
  // NOTE: every always_comb output gets a full default first so no path
  // leaves a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    acc_adj = acc;
    for (int d = 0; d < DIGITS; d++) begin
      if (acc[4*d +: 4] >= 4'd5)
        acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
    end
    acc_nxt = {acc_adj[4*DIGITS-2:0], sreg[WIDTH-1]};
  end

  // Significant digits of the final accumulator: highest nonzero digit + 1,
  // with an all-zero value still counting as one digit.
  always_comb begin
    ndig_nxt = 5'd1;
    for (int d = 0; d < DIGITS; d++) begin
      if (acc_nxt[4*d +: 4] != 4'd0)
        ndig_nxt = 5'(d + 1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sreg     <= '0;
      acc      <= '0;
      cnt      <= '0;
      neg_cap  <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.bcd  <= '0;
      bus.neg  <= 1'b0;
      bus.ndig <= 5'd1;
    end else begin
      bus.done <= 1'b0;
      case (state)
        // The edge leaving DONE is also an accepting edge, giving one
        // conversion every WIDTH+1 cycles when start is re-asserted at once.
        IDLE, DONE: begin
          if (bus.start) begin
            sreg     <= mag;
            acc      <= '0;
            cnt      <= '0;
            neg_cap  <= neg_in;
            bus.busy <= 1'b1;
            state    <= SHIFT;
          end else begin
            state    <= IDLE;
          end
        end

        SHIFT: begin
          acc  <= acc_nxt;
          sreg <= {sreg[WIDTH-2:0], 1'b0};
          cnt  <= cnt + CW'(1);
          // Old count WIDTH-1 means this edge performs the last shift, so the
          // results are registered straight from the final step.
          if (cnt == CW'(WIDTH - 1)) begin
            state    <= DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            bus.bcd  <= acc_nxt;
            bus.ndig <= ndig_nxt;
            bus.neg  <= neg_cap;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_result_conv.sv
// tb_bcd_result_conv
//   Directed bench for bcd_result_conv with hand-computed expected digits.
//   Build with +define+BCD_SIGNED_MAG_EN to exercise the signed-magnitude
//   option; the default build checks that sign is ignored.
module tb_bcd_result_conv;

  localparam int WIDTH  = 64;
  localparam int DIGITS = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;

  bcd_result_conv_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

  bcd_result_conv #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_bad  = 0;
  int n_done = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and sample 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.done) n_done++;
  endtask

  task automatic start_conv(input logic [WIDTH-1:0] val, input logic sgn);
    bus.sum   = val;
    bus.sign  = sgn;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Ticks until done is seen; lat is the number of edges taken (0 on timeout),
  // nbusy the number of those samples with busy high before done.
  task automatic wait_done(output int lat, output int nbusy);
    lat   = 0;
    nbusy = 0;
    for (int n = 1; n <= 200; n++) begin
      tick();
      if (bus.done) begin
        lat = n;
        break;
      end
      if (bus.busy) nbusy++;
    end
  endtask

  int lat, nbusy, b0, d0;

  initial begin
    bus.start = 1'b0;
    bus.sum   = '0;
    bus.sign  = 1'b0;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_bcd",  bus.bcd,  0);
    check("rst_neg",  bus.neg,  0);
    check("rst_ndig", bus.ndig, 1);

    // Zero: latency and busy duration
    start_conv(64'd0, 1'b0);
    b0 = bus.busy ? 1 : 0;
    wait_done(lat, nbusy);
    check("zero_lat",   lat, 64);
    check("zero_busyn", b0 + nbusy, 64);
    check("zero_busy0", bus.busy, 0);
    check("zero_bcd",   bus.bcd, 0);
    check("zero_ndig",  bus.ndig, 1);
    tick();
    check("zero_pulse", bus.done, 0);

    // Unsigned full scale
    start_conv(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    wait_done(lat, nbusy);
    check("max_bcd",  bus.bcd, 80'h18446744073709551615);
    check("max_ndig", bus.ndig, 20);
    check("max_neg",  bus.neg, 0);

    // Input change and start pulses during SHIFT are ignored
    d0 = n_done;
    start_conv(64'd12345, 1'b0);
    tick();
    bus.sum = 64'd999;
    tick();
    bus.start = 1'b1;
    tick(); tick();
    bus.start = 1'b0;
    wait_done(lat, nbusy);
    check("hold_lat",  lat + 4, 64);
    check("hold_bcd",  bus.bcd, 80'h12345);
    check("hold_ndig", bus.ndig, 5);
    for (int i = 0; i < 10; i++) tick();
    check("hold_ndone", n_done - d0, 1);
    check("hold_idle",  bus.busy, 0);
    check("hold_keep",  bus.bcd, 80'h12345);

    // Next conversion after return to IDLE uses the new sum
    start_conv(64'd999, 1'b0);
    check("n999_busy", bus.busy, 1);
    wait_done(lat, nbusy);
    check("n999_bcd",  bus.bcd, 80'h999);
    check("n999_ndig", bus.ndig, 3);

`ifdef BCD_SIGNED_MAG_EN
    start_conv(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    wait_done(lat, nbusy);
    check("sm1_bcd",  bus.bcd, 1);
    check("sm1_neg",  bus.neg, 1);
    check("sm1_ndig", bus.ndig, 1);
    start_conv(64'h8000_0000_0000_0000, 1'b1);
    wait_done(lat, nbusy);
    check("smmin_bcd",  bus.bcd, 80'h9223372036854775808);
    check("smmin_neg",  bus.neg, 1);
    check("smmin_ndig", bus.ndig, 19);
    start_conv(64'd42, 1'b0);
    wait_done(lat, nbusy);
    check("smpos_bcd", bus.bcd, 80'h42);
    check("smpos_neg", bus.neg, 0);
`else
    start_conv(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    wait_done(lat, nbusy);
    check("us_sign_bcd", bus.bcd, 80'h18446744073709551615);
    check("us_sign_neg", bus.neg, 0);
`endif

    // Reset 30 cycles into a conversion of 2^40
    d0 = n_done;
    start_conv(64'd1 << 40, 1'b0);
    for (int i = 0; i < 29; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", bus.busy, 0);
    check("abort_bcd",  bus.bcd, 0);
    check("abort_ndig", bus.ndig, 1);
    for (int i = 0; i < 80; i++) tick();
    check("abort_ndone", n_done - d0, 0);
    start_conv(64'd1 << 40, 1'b0);
    wait_done(lat, nbusy);
    check("p40_lat",  lat, 64);
    check("p40_bcd",  bus.bcd, 80'h1099511627776);
    check("p40_ndig", bus.ndig, 13);

    // Back-to-back: restart on the edge right after done
    start_conv(64'd7, 1'b0);
    wait_done(lat, nbusy);
    check("b2b1_bcd",  bus.bcd, 80'h7);
    check("b2b1_ndig", bus.ndig, 1);
    start_conv(64'd1000000, 1'b0);
    check("b2b2_busy", bus.busy, 1);
    wait_done(lat, nbusy);
    check("b2b_gap",   lat + 1, 65);
    check("b2b2_bcd",  bus.bcd, 80'h1000000);
    check("b2b2_ndig", bus.ndig, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
